cpu_run_ctrl: RTL and testbench

Run-mode controller for the CPU core. It debounces the raw step key and produces the core's single-cycle clock-enable `cpu_en`, so a program can be stepped one instruction at a time, burst-run for N instructions, free-run, or free-run to a PC breakpoint. It replaces the fixed debounced-key-as-clock scheme. All core state elements run on `clk` gated by `cpu_en`.

---
 rtl/cpu_run_ctrl_pkg.sv | 8 +
 rtl/cpu_run_ctrl_key_debounce.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 87 ++++++++
 tb/tb_cpu_run_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: run-mode encodings and controller state type shared by the run controller files
package cpu_run_ctrl_pkg;
  localparam logic [1:0] RunStep  = 2'b00;
  localparam logic [1:0] RunBurst = 2'b01;
  localparam logic [1:0] RunFree  = 2'b10;
  localparam logic [1:0] RunBp    = 2'b11;
  typedef enum logic [2:0] {IDLE, STEP, BURST, RUN, HALTED} state_t;
endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// key_debounce: 2-flop sync + DEB_CYCLES-stable debounce of active-low key_in; press pulses on debounced 1->0, deb_level is the debounced key
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic RST,
  input  logic key_in,
  output logic press,
  output logic deb_level
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (RST) begin
      sync <= 2'b11;
      cnt <= '0;
      deb_level <= 1'b1;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      press <= 1'b0;
      if (sync[1] == deb_level) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        deb_level <= sync[1];
        press <= deb_level;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: step/burst/run/run-to-breakpoint clock-enable controller; in clk RST key_in mode burst_len bp_addr pc halt_req, out cpu_en busy bp_hit step_count
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int BURST_W = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               key_in,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic               halt_req,
  output logic               cpu_en,
  output logic               busy,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   step_count
);
  state_t state, state_nxt;
  logic press, deb_level, key_evt, en, bp_term, stop, first;
  logic [1:0] mode_q;
  logic [BURST_W-1:0] remaining;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .RST(RST),
    .key_in(key_in),
    .press(press),
    .deb_level(deb_level)
  );
  // a press pulse always coincides with the debounced level reaching "pressed"
  assign key_evt = press & ~deb_level;
  // the breakpoint is ignored on the first RUN cycle so resuming executes the instruction at bp_addr
  assign bp_term = state == RUN && mode_q == RunBp && pc == bp_addr && !first;
  assign stop = halt_req || bp_term;
  always_comb begin
    state_nxt = state;
    en = 1'b0;
    case (state)
      IDLE: if (key_evt) state_nxt = mode == RunStep ? STEP : mode == RunBurst ? (burst_len != '0 ? BURST : IDLE) : RUN;
      STEP: begin
        en = 1'b1;
        state_nxt = IDLE;
      end
      BURST: begin
        state_nxt = halt_req ? HALTED : key_evt ? IDLE : remaining == BURST_W'(1) ? IDLE : BURST;
        en = !halt_req && !key_evt;
      end
      RUN: begin
        state_nxt = stop ? HALTED : key_evt ? IDLE : RUN;
        en = !stop && !key_evt;
      end
      HALTED: if (key_evt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // reset suppresses the enable in the very cycle it is sampled
  assign cpu_en = en & ~RST;
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      mode_q <= RunStep;
      remaining <= '0;
      first <= 1'b0;
      busy <= 1'b0;
      bp_hit <= 1'b0;
      step_count <= '0;
    end else begin
      state <= state_nxt;
      busy <= state_nxt == BURST || state_nxt == RUN;
      step_count <= step_count + CNT_W'(en);
      if (state == IDLE && key_evt) begin
        mode_q <= mode;
        remaining <= burst_len;
        first <= mode[1];
      end else begin
        if (state == BURST && en) remaining <= remaining - BURST_W'(1);
        if (state == RUN) first <= 1'b0;
      end
      if (state == RUN && stop) bp_hit <= bp_term && !halt_req;
      else if (state == HALTED && key_evt) bp_hit <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized scoreboard bench for cpu_run_ctrl with an instruction-count reference model
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;
  localparam int CNT_W = 10;
  localparam int INF = 1 << 30;
  logic clk = 1'b0, RST = 1'b1, key_in = 1'b1;
  logic [1:0] mode = RunStep;
  logic [7:0] burst_len = '0;
  logic [31:0] bp_addr = 32'h3, pc = '0, halt_pc = 32'h1;
  logic halt_req, cpu_en, busy, bp_hit;
  logic [CNT_W-1:0] step_count;
  int total = 0, bad = 0, exp_steps = 0;
  typedef struct packed {logic [31:0] pc; logic busy;} exp_t;
  exp_t sb[$];
  cpu_run_ctrl #(.PC_W(32), .BURST_W(8), .DEB_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .RST(RST), .key_in(key_in), .mode(mode), .burst_len(burst_len),
    .bp_addr(bp_addr), .pc(pc), .halt_req(halt_req), .cpu_en(cpu_en),
    .busy(busy), .bp_hit(bp_hit), .step_count(step_count)
  );
  always #5 clk = ~clk;
  // core model: the instruction at pc retires on each enable; an illegal opcode sits at halt_pc
  assign halt_req = pc == halt_pc;
  always @(posedge clk) if (cpu_en) pc <= pc + 32'd4;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cpu_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_enable got cpu_en=1 at pc=%h want cpu_en=0", pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("enable_pc", pc, e.pc);
        chk("enable_busy", 32'(busy), 32'(e.busy));
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      mode = 2'($urandom);
      burst_len = 8'($urandom);
      tick(1);
    end
  endtask
  task automatic press_key();
    key_in = 1'b0;
    tick(8);
    key_in = 1'b1;
    tick(8);
  endtask
  task automatic chk_count(input string n);
    chk(n, 32'(step_count), 32'(exp_steps % (1 << CNT_W)));
  endtask
  // one operation: kh/kb = instruction index of halt opcode / breakpoint (-1 none), w = gap before an aborting press (-1 none)
  task automatic episode(input logic [1:0] m, input int n, input int kh, input int kb, input int w);
    int p, k, kbe, kmin, cnt;
    bit halted, bph;
    mode = m;
    burst_len = 8'(n);
    halt_pc = kh < 0 ? 32'h1 : pc + 32'(4 * kh);
    bp_addr = kb < 0 ? 32'h3 : pc + 32'(4 * kb);
    p = w < 0 ? INF : 15 + w;
    k = kh < 0 ? INF : kh;
    kbe = (m == RunBp && kb >= 1) ? kb : INF;
    halted = 1'b0;
    bph = 1'b0;
    if (m == RunStep) cnt = 1;
    else if (m == RunBurst) begin
      if (n == 0) cnt = 0;
      else if (k < n && k <= p) begin
        cnt = k;
        halted = 1'b1;
      end else cnt = p < n ? p : n;
    end else begin
      kmin = k < kbe ? k : kbe;
      if (kmin <= p) begin
        cnt = kmin;
        halted = 1'b1;
        bph = kbe < k;
      end else cnt = p;
    end
    for (int i = 0; i < cnt; i++) sb.push_back('{pc + 32'(4 * i), m != RunStep});
    exp_steps += cnt;
    press_key();
    if (w >= 0) begin
      tick(w);
      press_key();
    end
    idle_wait(cnt + 4);
    chk("pending_enables", 32'(sb.size()), 0);
    chk("busy_end", 32'(busy), 0);
    chk("bp_hit_end", 32'(bp_hit), 32'(bph));
    chk_count("step_count_end");
    if (halted) begin
      mode = RunStep;
      press_key();
      idle_wait(3);
      chk("bp_hit_clear", 32'(bp_hit), 0);
      chk_count("step_count_halt");
    end
  endtask
  initial begin
    int r, kh, kb;
    tick(3);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bp_hit", 32'(bp_hit), 0);
    chk("rst_step_count", 32'(step_count), 0);
    RST = 1'b0;
    tick(2);
    mode = RunStep;
    sb.push_back('{pc, 1'b0});
    exp_steps = 1;
    for (int i = 0; i < 10; i++) begin
      key_in = 1'(i % 2);
      tick(1);
    end
    key_in = 1'b0;
    tick(6);
    @(negedge clk);
    chk("bounce_early", 32'(cpu_en), 0);
    tick(1);
    @(negedge clk);
    chk("bounce_en", 32'(cpu_en), 1);
    tick(1);
    @(negedge clk);
    chk("bounce_single", 32'(cpu_en), 0);
    tick(1);
    key_in = 1'b1;
    tick(12);
    chk_count("bounce_count");
    episode(RunBurst, 5, -1, -1, -1);
    episode(RunBurst, 0, -1, -1, -1);
    episode(RunBp, 0, -1, 4, -1);
    episode(RunBp, 0, 3, 0, -1);
    episode(RunBp, 0, 18, 18, 3);
    episode(RunBurst, 200, -1, -1, 0);
    episode(RunFree, 0, -1, -1, 2);
    for (int e = 0; e < 30; e++) begin
      r = $urandom_range(0, 5);
      kh = $urandom_range(0, 1) == 1 ? int'($urandom_range(0, 14)) : -1;
      kb = $urandom_range(0, 10);
      case (r)
        0: episode(RunStep, 0, -1, -1, -1);
        1: episode(RunBurst, $urandom_range(0, 12), kh, -1, -1);
        2: episode(RunBurst, 200, -1, -1, $urandom_range(0, 20));
        3: episode(RunFree, 0, $urandom_range(0, 20), kb, -1);
        4: episode(RunBp, 0, (kb == 0 && kh < 0) ? 6 : kh, kb, -1);
        default: episode(RunFree, 0, -1, -1, $urandom_range(0, 20));
      endcase
    end
    mode = RunFree;
    halt_pc = 32'h1;
    for (int i = 0; i < 12; i++) sb.push_back('{pc + 32'(4 * i), 1'b1});
    press_key();
    tick(3);
    RST = 1'b1;
    @(negedge clk);
    chk("rst_mid_run_en", 32'(cpu_en), 0);
    tick(1);
    RST = 1'b0;
    exp_steps = 0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_bp_hit", 32'(bp_hit), 0);
    chk("rst_mid_count", 32'(step_count), 0);
    chk("rst_mid_pending", 32'(sb.size()), 0);
    tick(4);
    episode(RunFree, 0, 1100, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
